sr_pulse_sequencer: RTL

Sequencer that drives the active-low asynchronous set (S_N) and reset (R_N) pins of a WIDTH-bit bank of DFFSR cells. It is the stage directly upstream of the bank. It accepts a load request (value plus bit mask) and forces the masked bits through the async pins with a guaranteed minimum pulse width. It then holds a recovery window before re-enabling bank clocking. Outputs are registered, glitch-free, and never assert S_N and R_N together on the same bit.

---
 rtl/sr_pulse_sequencer_pkg.sv | 20 ++
 rtl/sr_pulse_sequencer_if.sv | 27 ++
 rtl/sr_pulse_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sr_pulse_sequencer_pkg.sv
// sr_seq_pkg -- shared types and helpers for sr_pulse_sequencer.
//   sr_state_t : sequencer FSM states (IDLE, ASSERT, RECOVER).
//   cnt_width  : width of the pulse/recovery down-counter.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RECOVER = 2'd2
  } sr_state_t;

  // The counter must be able to hold the larger of the two window lengths.
  function automatic int cnt_width(input int pw, input int rec);
    int m;
    m = (pw > rec) ? pw : rec;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_pulse_sequencer_if.sv
// sr_pulse_sequencer_if -- load-request handshake into the sequencer.
//   req_valid : request valid (master -> slave)
//   req_ready : sequencer can accept (slave -> master)
//   req_val   : value to force into the bank
//   req_mask  : 1 = force this bit, 0 = leave untouched
interface sr_pulse_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_val;
  logic [WIDTH-1:0] req_mask;

  modport master (
    output req_valid,
    output req_val,
    output req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_val,
    input  req_mask,
    output req_ready
  );
endinterface

// File: rtl/sr_pulse_sequencer.sv
// sr_pulse_sequencer -- drives the active-low async set/reset pins of a
// WIDTH-bit DFFSR bank. A masked load is forced through S_N/R_N for PW_CYC
// cycles, then the pins are released for REC_CYC cycles before bank
// clocking (o_clk_en) returns. Every output is a flop.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   req_if    : request handshake (slave side: valid/val/mask in, ready out)
//   o_s_n     : active-low set, one bit per cell
//   o_r_n     : active-low reset, one bit per cell
//   o_clk_en  : bank capture enable, low during pulse and recovery
//   o_busy    : a sequence is in progress
//   o_done    : one-cycle pulse when a sequence completes
module sr_pulse_sequencer
  import sr_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PW_CYC  = 2,
  parameter int REC_CYC = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sr_pulse_sequencer_if.slave  req_if,
  output logic [WIDTH-1:0]     o_s_n,
  output logic [WIDTH-1:0]     o_r_n,
  output logic                 o_clk_en,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = cnt_width(PW_CYC, REC_CYC);

  localparam logic [1:0]    ST_IDLE    = IDLE;
  localparam logic [1:0]    ST_ASSERT  = ASSERT;
  localparam logic [1:0]    ST_RECOVER = RECOVER;

  localparam logic [CW-1:0] PW_LD  = CW'(PW_CYC - 1);
  localparam logic [CW-1:0] REC_LD = CW'(REC_CYC - 1);

  if (PW_CYC < 1 || REC_CYC < 1) begin : g_bad_param
    $error("sr_pulse_sequencer: PW_CYC and REC_CYC must both be >= 1");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_s_n;
  logic [WIDTH-1:0] r_r_n;
  logic             r_clk_en;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  logic             w_accept;
  logic [1:0]       w_state_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic             w_done_nx;
  logic [WIDTH-1:0] w_val_sel;
  logic [WIDTH-1:0] w_mask_sel;
  logic [WIDTH-1:0] w_s_n_nx;
  logic [WIDTH-1:0] w_r_n_nx;

  assign w_accept   = req_if.req_valid & r_ready;
  // Freshly accepted data is used directly so the pins assert in the first
  // cycle after the accept edge.
  assign w_val_sel  = w_accept ? req_if.req_val  : r_val;
  assign w_mask_sel = w_accept ? req_if.req_mask : r_mask;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (|req_if.req_mask) begin
            w_state_nx = ST_ASSERT;
            w_cnt_nx   = PW_LD;
          end else begin
            w_done_nx  = 1'b1;
          end
        end
      end
      ST_ASSERT: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_RECOVER;
          w_cnt_nx   = REC_LD;
        end else begin
          w_cnt_nx   = r_cnt - CW'(1);
        end
      end
      ST_RECOVER: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // S and R are derived from disjoint halves of the mask, so a bit can never
  // have both pins low.
  always_comb begin
    w_s_n_nx = '1;
    w_r_n_nx = '1;
    if (w_state_nx == ST_ASSERT) begin
      w_s_n_nx = ~(w_mask_sel & w_val_sel);
      w_r_n_nx = ~(w_mask_sel & ~w_val_sel);
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_s_n    <= '1;
      r_r_n    <= '1;
      r_clk_en <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_s_n    <= w_s_n_nx;
      r_r_n    <= w_r_n_nx;
      r_clk_en <= (w_state_nx == ST_IDLE);
      r_busy   <= (w_state_nx != ST_IDLE);
      r_done   <= w_done_nx;
      r_ready  <= (w_state_nx == ST_IDLE);
    end
  end

  // Request data capture.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_val  <= req_if.req_val;
      r_mask <= req_if.req_mask;
    end
  end

  assign req_if.req_ready = r_ready;
  assign o_s_n            = r_s_n;
  assign o_r_n            = r_r_n;
  assign o_clk_en         = r_clk_en;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule
